// File: rtl/ysyx_22040127_mem_arbiter.sv
// Round-robin IFU/LSU arbiter for the shared pmem port.
// One access at a time: request, wait for data, one-cycle response.
module ysyx_22040127_mem_arbiter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_i,
    input  logic [63:0] ifu_addr_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_err_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [63:0] lsu_addr_i,
    input  logic [1:0]  lsu_size_i,
    input  logic [63:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [63:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wmask_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_q;
    logic          owner_q;
    logic          last_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   rdata_q;
    logic          err_q;
    logic          irv_q;
    logic          lrv_q;
    logic          mreq_q;

    logic          sel_lsu;
    logic          any_gnt;
    logic [63:0]   g_addr;
    logic [1:0]    g_size;
    logic [2:0]    amask;
    logic          mis;
    logic [63:0]   rdata_d;
    logic [7:0]    wmask_d;

    // Grant selection and alignment check of the candidate request.
    always_comb begin
        sel_lsu   = lsu_req_i & (~ifu_req_i | ~last_q);
        ifu_gnt_o = (state_q == IDLE) & ~rst & ifu_req_i & ~sel_lsu;
        lsu_gnt_o = (state_q == IDLE) & ~rst & sel_lsu;
        any_gnt   = ifu_gnt_o | lsu_gnt_o;
        g_addr    = sel_lsu ? lsu_addr_i : ifu_addr_i;
        g_size    = sel_lsu ? lsu_size_i : 2'd2;
        amask     = 3'b000;
        unique case (g_size)
            2'd0: amask = 3'b000;
            2'd1: amask = 3'b001;
            2'd2: amask = 3'b011;
            2'd3: amask = 3'b111;
        endcase
        mis = |(g_addr[2:0] & amask);
    end

    // Response data: IFU takes the addressed word, LSU the shifted doubleword.
    always_comb begin
        rdata_d = '0;
        if (owner_q)
            rdata_d = mem_rdata_i >> {addr_q[2:0], 3'b000};
        else
            rdata_d = {32'b0, addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0]};
    end

    // Byte enables from size, placed at the byte offset.
    always_comb begin
        wmask_d = 8'h00;
        unique case (size_q)
            2'd0: wmask_d = 8'h01;
            2'd1: wmask_d = 8'h03;
            2'd2: wmask_d = 8'h0F;
            2'd3: wmask_d = 8'hFF;
        endcase
        wmask_d = wmask_d << addr_q[2:0];
    end

    // Access sequencer with registered request and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            irv_q   <= 1'b0;
            lrv_q   <= 1'b0;
            mreq_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (any_gnt) begin
                    owner_q <= sel_lsu;
                    last_q  <= sel_lsu;
                    addr_q  <= g_addr;
                    size_q  <= g_size;
                    we_q    <= sel_lsu & lsu_we_i;
                    wdata_q <= sel_lsu ? lsu_wdata_i : 64'd0;
                    cnt_q   <= '0;
                    if (mis) begin
                        state_q <= RESP;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        irv_q   <= ~sel_lsu;
                        lrv_q   <= sel_lsu;
                    end else begin
                        state_q <= REQ;
                        mreq_q  <= 1'b1;
                    end
                end
                REQ: if (mem_ready_i) begin
                    mreq_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_q <= rdata_d;
                        err_q   <= 1'b0;
                        irv_q   <= ~owner_q;
                        lrv_q   <= owner_q;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(MAX_WAIT)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        irv_q   <= ~owner_q;
                        lrv_q   <= owner_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    irv_q   <= 1'b0;
                    lrv_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ifu_rvalid_o = irv_q;
    assign ifu_rdata_o  = rdata_q[31:0];
    assign ifu_err_o    = irv_q & err_q;
    assign lsu_rvalid_o = lrv_q;
    assign lsu_rdata_o  = rdata_q;
    assign lsu_err_o    = lrv_q & err_q;
    assign mem_req_o    = mreq_q;
    assign mem_we_o     = mreq_q & we_q;
    assign mem_addr_o   = {addr_q[63:3], 3'b000};
    assign mem_wdata_o  = wdata_q << {addr_q[2:0], 3'b000};
    assign mem_wmask_o  = (mreq_q & we_q) ? wmask_d : 8'h00;

endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
// Drives inputs on the falling edge and samples 1 ns later.
module tb_ysyx_22040127_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        ifu_gnt, ifu_rvalid, ifu_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req, lsu_we;
    logic [63:0] lsu_addr, lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_gnt, lsu_rvalid, lsu_err;
    logic [63:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;

    int n_chk = 0;
    int n_fail = 0;
    logic early;

    always #5 clk = ~clk;

    ysyx_22040127_mem_arbiter #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr),
        .ifu_gnt_o(ifu_gnt), .ifu_rvalid_o(ifu_rvalid),
        .ifu_rdata_o(ifu_rdata), .ifu_err_o(ifu_err),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
        .lsu_size_i(lsu_size), .lsu_wdata_i(lsu_wdata),
        .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid),
        .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifu_req = 0; ifu_addr = 0;
        lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_size = 0; lsu_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ifu_rv", ifu_rvalid, 0);
        chk("rst_lsu_rv", lsu_rvalid, 0);
        chk("rst_gnt", {ifu_gnt, lsu_gnt}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wmask", mem_wmask, 0);
        @(negedge clk); rst = 1'b0;

        // IFU best-case fetch
        @(negedge clk);
        ifu_req = 1; ifu_addr = 64'h8000_0004; mem_ready = 1;
        mem_rdata = 64'h1111_2222_3333_4444;
        #1 chk("t1_gnt", ifu_gnt, 1);
        @(negedge clk); ifu_req = 0;
        #1 chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 64'h8000_0000);
        chk("t1_we", mem_we, 0);
        @(negedge clk); mem_rvalid = 1;
        #1 chk("t1_wait", mem_req, 0);
        @(negedge clk); mem_rvalid = 0;
        #1 chk("t1_rv", ifu_rvalid, 1);
        chk("t1_rdata", ifu_rdata, 64'h1111_2222);
        chk("t1_err", ifu_err, 0);
        chk("t1_lsu_rv", lsu_rvalid, 0);
        @(negedge clk);
        #1 chk("t1_rv_off", ifu_rvalid, 0);

        // Round-robin with both requesting continuously
        rst = 1;
        @(negedge clk); rst = 0;
        @(negedge clk);
        ifu_req = 1; ifu_addr = 64'h8000_0000;
        lsu_req = 1; lsu_we = 0; lsu_addr = 64'h100; lsu_size = 3;
        mem_ready = 1; mem_rvalid = 1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("rr_lgnt%0d", c), lsu_gnt, (c % 8) == 0);
            chk($sformatf("rr_ignt%0d", c), ifu_gnt, (c % 8) == 4);
            if (c == 3) begin
                chk("rr_lrv", lsu_rvalid, 1);
                chk("rr_ldata", lsu_rdata, 64'h1111_2222_3333_4444);
            end
            if (c == 7) begin
                chk("rr_irv", ifu_rvalid, 1);
                chk("rr_idata", ifu_rdata, 64'h3333_4444);
            end
        end
        @(negedge clk);
        ifu_req = 0; lsu_req = 0; mem_rvalid = 0;

        // LSU halfword store at byte offset 6
        @(negedge clk);
        lsu_req = 1; lsu_we = 1; lsu_addr = 64'h8000_0006;
        lsu_size = 1; lsu_wdata = 64'hABCD; mem_ready = 0;
        #1 chk("sh_gnt", lsu_gnt, 1);
        @(negedge clk); lsu_req = 0;
        #1 chk("sh_req", mem_req, 1);
        chk("sh_addr", mem_addr, 64'h8000_0000);
        chk("sh_mask", mem_wmask, 8'hC0);
        chk("sh_wdata", mem_wdata, 64'hABCD_0000_0000_0000);
        chk("sh_we", mem_we, 1);
        mem_ready = 1;
        @(negedge clk); mem_rvalid = 1;
        @(negedge clk); mem_rvalid = 0;
        #1 chk("sh_rv", lsu_rvalid, 1);
        chk("sh_err", lsu_err, 0);

        // LSU byte load at offset 5
        @(negedge clk);
        lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_0005; lsu_size = 0;
        mem_rdata = 64'h1122_3344_5566_7788;
        #1 chk("lb_gnt", lsu_gnt, 1);
        @(negedge clk); lsu_req = 0;
        #1 chk("lb_mask", mem_wmask, 0);
        chk("lb_we", mem_we, 0);
        @(negedge clk); mem_rvalid = 1;
        @(negedge clk); mem_rvalid = 0;
        #1 chk("lb_rv", lsu_rvalid, 1);
        chk("lb_rdata", lsu_rdata, 64'h11_2233);

        // Misaligned LSU word and IFU fetch
        @(negedge clk);
        lsu_req = 1; lsu_addr = 64'h8000_0002; lsu_size = 2;
        #1 chk("mis_lgnt", lsu_gnt, 1);
        @(negedge clk); lsu_req = 0;
        #1 chk("mis_lreq", mem_req, 0);
        chk("mis_lrv", lsu_rvalid, 1);
        chk("mis_lerr", lsu_err, 1);
        chk("mis_ldata", lsu_rdata, 0);
        @(negedge clk);
        ifu_req = 1; ifu_addr = 64'h8000_0006;
        #1 chk("mis_ignt", ifu_gnt, 1);
        @(negedge clk); ifu_req = 0;
        #1 chk("mis_ireq", mem_req, 0);
        chk("mis_irv", ifu_rvalid, 1);
        chk("mis_ierr", ifu_err, 1);

        // Stalled request then timeout
        @(negedge clk);
        ifu_req = 1; ifu_addr = 64'h8000_0000; mem_ready = 0;
        #1 chk("to_gnt", ifu_gnt, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            ifu_req = 0;
            if (k == 6) mem_ready = 1;
            #1 chk($sformatf("to_req%0d", k), mem_req, 1);
        end
        early = 0;
        for (int k = 7; k <= 23; k++) begin
            @(negedge clk);
            mem_ready = 0;
            #1 if (ifu_rvalid) early = 1;
            if (k == 7) chk("to_req_off", mem_req, 0);
        end
        chk("to_early", early, 0);
        @(negedge clk);
        #1 chk("to_rv", ifu_rvalid, 1);
        chk("to_err", ifu_err, 1);
        chk("to_data", ifu_rdata, 0);

        // Reset during WAIT abandons the access
        @(negedge clk);
        ifu_req = 1; mem_ready = 1;
        #1 chk("rw_gnt", ifu_gnt, 1);
        @(negedge clk); ifu_req = 0;
        @(negedge clk); rst = 1;
        #1 chk("rw_req", mem_req, 0);
        chk("rw_rv", {ifu_rvalid, lsu_rvalid}, 0);
        @(negedge clk); rst = 0; mem_rvalid = 1;
        #1 chk("rw_rv1", {ifu_rvalid, lsu_rvalid}, 0);
        @(negedge clk); mem_rvalid = 0;
        #1 chk("rw_rv2", {ifu_rvalid, lsu_rvalid}, 0);
        @(negedge clk);
        ifu_req = 1; lsu_req = 1; lsu_addr = 64'h100; lsu_size = 3;
        #1 chk("rw_lgnt", lsu_gnt, 1);
        chk("rw_ignt", ifu_gnt, 0);
        @(negedge clk);
        ifu_req = 0; lsu_req = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22040127_mem_arbiter.md
# ysyx_22040127_mem_arbiter

Shares the single doubleword-aligned physical memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Arbitrates requests round-robin, sequences each access through a request/ack/response FSM, builds byte-lane write data and write masks from LSU address and size, and bounds every access with a timeout. Sits between IFU/LSU and the DPI-backed pmem wrapper.

## Interface

- MAX_WAIT, 16, cycles in WAIT without mem_rvalid before an error response (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req  in  1  fetch request; held until ifu_gnt
- ifu_addr  in  64  fetch address, must be 4-byte aligned
- ifu_gnt  out  1  request accepted this cycle
- ifu_rvalid  out  1  one-cycle response pulse
- ifu_rdata  out  32  instruction word: doubleword half selected by latched addr[2]
- ifu_err  out  1  valid with ifu_rvalid: misaligned or timeout
- lsu_req  in  1  load/store request; held until lsu_gnt
- lsu_we  in  1  1 = store
- lsu_addr  in  64  byte address
- lsu_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- lsu_wdata  in  64  store data, LSB-justified
- lsu_gnt, lsu_rvalid, lsu_err  out  1 each  as IFU
- lsu_rdata  out  64  raw doubleword shifted right by addr[2:0]*8; LSU sign/zero-extends
- mem_req  out  1  access valid
- mem_we  out  1  store
- mem_addr  out  64  {addr[63:3], 3'b0}
- mem_wdata  out  64  lsu_wdata << addr[2:0]*8
- mem_wmask  out  8  byte enables; 0 for reads
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  64  aligned doubleword

## Operation

- States: IDLE, REQ, WAIT, RESP.
- IDLE: if exactly one requester is active, grant it; if both, grant the one not equal to last_owner. gnt is combinational, asserted only in IDLE. Request fields latched at the granting edge; last_owner updated.
- Misalignment check at grant: IFU addr[1:0]≠0; LSU addr not aligned to 2^size. Misaligned → skip memory, go to RESP with err=1, rdata=0.
- Otherwise IDLE→REQ. REQ: mem_req=1 with latched fields; transfer when mem_req&mem_ready → WAIT.
- WAIT: counter increments each cycle. mem_rvalid → latch data, RESP, err=0. Counter reaches MAX_WAIT without mem_rvalid → RESP, err=1, rdata=0.
- RESP: owner's rvalid=1 for exactly one cycle, then IDLE. Non-owner rvalid stays 0.
- wmask: size 0→8'h01, 1→8'h03, 2→8'h0F, 3→8'hFF, shifted left by addr[2:0]; forced 0 when we=0.
- mem_rvalid outside WAIT is ignored.
- REQ has no timeout: mem_req held indefinitely until mem_ready.

## Timing

- Reset: state IDLE, last_owner=IFU (LSU wins first tie), counter 0, every output 0.
- Reset mid-access abandons it; no response is issued.
- Best case: gnt at T, mem_req at T+1 with mem_ready=1, mem_rvalid at T+2, rvalid at T+3, next gnt at T+4 earliest.
- Misaligned: gnt at T, rvalid/err at T+1.
- Timeout: rvalid/err asserted MAX_WAIT+1 cycles after entering WAIT.
- mem_* outputs stable throughout REQ. rdata and err are registered and valid only with rvalid.

## Test plan

- IFU only, addr 0x8000_0004, mem_rdata 0x1111_2222_3333_4444, ready=1, rvalid one cycle later → ifu_gnt T, ifu_rvalid T+3, ifu_rdata 0x1111_2222, err 0.
- Both request every cycle from reset → grants LSU, IFU, LSU, IFU; each grant 4 cycles apart.
- LSU sh addr 0x...0006, wdata 0xABCD → mem_addr 0x...0000, mem_wmask 8'hC0, mem_wdata 0xABCD_0000_0000_0000, mem_we 1.
- LSU lw addr 0x...0002 → no mem_req; lsu_rvalid and lsu_err at T+1. IFU addr 0x...0006 → same.
- mem_ready low 5 cycles, then high; mem_rvalid never arrives, MAX_WAIT=16 → mem_req held 6 cycles, then err response 17 cycles after entering WAIT.
- rst asserted during WAIT → outputs 0 immediately; later mem_rvalid produces no response; next grant goes to LSU on a tie.
